// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the multi-cycle MIPS datapath; CTRL_PERF_CNT_EN adds retired/stall_cycles counters
module multicycle_control #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       neg,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       branch_taken,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] stall_cycles
`endif
);
  // beq/bgez/balz share one BRANCH state so all states fit the 4-bit debug encoding
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD,
    WB_MEM, MEM_WR, JM_RD, JM_PC, JUMP, BRANCH, LINK
  } state_e;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_JM = 6'b010000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ANDI = 6'b001100, OP_J = 6'b000010;
  localparam logic [5:0] OP_BGEZ = 6'b100111, OP_BALZ = 6'b011010;
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic en, last, cond;
  assign en = ~reset;
  assign last = cnt_q == LAST;
  assign cond = opcode == OP_BEQ ? zero : opcode == OP_BGEZ ? ~neg : neg;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = last ? DECODE : FETCH;
      DECODE:
        case (opcode)
          OP_R:                    state_d = EXEC_R;
          OP_LW, OP_SW, OP_JM:     state_d = ADDR;
          OP_BEQ, OP_BGEZ, OP_BALZ: state_d = BRANCH;
          OP_ANDI:                 state_d = EXEC_I;
          OP_J:                    state_d = JUMP;
          default:                 state_d = FETCH;
        endcase
      EXEC_R:  state_d = WB_R;
      EXEC_I:  state_d = WB_I;
      ADDR:    state_d = opcode == OP_LW ? MEM_RD : opcode == OP_SW ? MEM_WR : JM_RD;
      MEM_RD:  state_d = last ? WB_MEM : MEM_RD;
      MEM_WR:  state_d = last ? FETCH : MEM_WR;
      JM_RD:   state_d = last ? JM_PC : JM_RD;
      BRANCH:  state_d = (opcode == OP_BALZ && neg) ? LINK : FETCH;
      default: state_d = FETCH;
    endcase
    cnt_d = state_d == state_q ? cnt_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pcwrite      = en & ((state_q == FETCH & last) | state_q == JM_PC | state_q == JUMP);
  assign pcwritecond  = en & state_q == BRANCH;
  assign branch_taken = en & state_q == BRANCH & cond;
  assign iord         = en & (state_q == MEM_RD | state_q == MEM_WR | state_q == JM_RD);
  assign memread      = en & (state_q == FETCH | state_q == MEM_RD | state_q == JM_RD);
  assign memwrite     = en & state_q == MEM_WR;
  assign irwrite      = en & state_q == FETCH & last;
  assign regdst       = !en ? 2'b00 : state_q == WB_R ? 2'b01 : state_q == LINK ? 2'b10 : 2'b00;
  assign memtoreg     = !en ? 2'b00 : state_q == WB_MEM ? 2'b01 : state_q == LINK ? 2'b10 : 2'b00;
  assign regwrite     = en & (state_q == WB_R | state_q == WB_I | state_q == WB_MEM | state_q == LINK);
  assign alusrca      = en & (state_q == EXEC_R | state_q == EXEC_I | state_q == ADDR | state_q == BRANCH);
  assign alusrcb      = !en ? 2'b00 : state_q == FETCH ? 2'b01 : state_q == DECODE ? 2'b11 :
                        (state_q == EXEC_I | state_q == ADDR) ? 2'b10 : 2'b00;
  assign aluop        = !en ? 2'b00 : state_q == EXEC_R ? 2'b10 : state_q == EXEC_I ? 2'b11 :
                        state_q == BRANCH ? 2'b01 : 2'b00;
  assign pcsource     = !en ? 2'b00 : state_q == BRANCH ? 2'b01 : state_q == JUMP ? 2'b10 :
                        state_q == JM_PC ? 2'b11 : 2'b00;
  assign illegal      = en & state_q == DECODE & state_d == FETCH;
  assign state_o      = en ? state_q : 4'd0;
`ifdef CTRL_PERF_CNT_EN
  logic mem_st;
  assign mem_st = state_q inside {FETCH, MEM_RD, MEM_WR, JM_RD};
  // DECODE only falls back to FETCH on an illegal opcode, which must not retire
  always_ff @(posedge clk) begin
    if (reset) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      retired      <= retired + 32'(state_d == FETCH && state_q != FETCH && state_q != DECODE);
      stall_cycles <= stall_cycles + 32'(mem_st && !last);
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven scoreboard bench running MEM_LAT=1 and MEM_LAT=3 instances side by side
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, neg = 1'b0;
  logic [5:0] opcode = 6'd0;
  wire [23:0] o1, o3;
`ifdef CTRL_PERF_CNT_EN
  wire [31:0] ret1, stl1, ret3, stl3;
`endif
  always #5 clk = ~clk;

  multicycle_control #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .neg(neg),
    .pcwrite(o1[19]), .pcwritecond(o1[18]), .branch_taken(o1[17]), .iord(o1[16]),
    .memread(o1[15]), .memwrite(o1[14]), .irwrite(o1[13]), .regdst(o1[12:11]),
    .memtoreg(o1[10:9]), .regwrite(o1[8]), .alusrca(o1[7]), .alusrcb(o1[6:5]),
    .aluop(o1[4:3]), .pcsource(o1[2:1]), .illegal(o1[0]), .state_o(o1[23:20])
`ifdef CTRL_PERF_CNT_EN
    , .retired(ret1), .stall_cycles(stl1)
`endif
  );
  multicycle_control #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .neg(neg),
    .pcwrite(o3[19]), .pcwritecond(o3[18]), .branch_taken(o3[17]), .iord(o3[16]),
    .memread(o3[15]), .memwrite(o3[14]), .irwrite(o3[13]), .regdst(o3[12:11]),
    .memtoreg(o3[10:9]), .regwrite(o3[8]), .alusrca(o3[7]), .alusrcb(o3[6:5]),
    .aluop(o3[4:3]), .pcsource(o3[2:1]), .illegal(o3[0]), .state_o(o3[23:20])
`ifdef CTRL_PERF_CNT_EN
    , .retired(ret3), .stall_cycles(stl3)
`endif
  );

  // {state, pcw, pcwc, bt, iord, mr, mw, irw, regdst, memtoreg, rw, alusrca, alusrcb, aluop, pcsource, illegal}
  localparam logic [23:0] Z   = 24'd0;
  localparam logic [23:0] F_W = {4'd0,  7'b0000100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] F_L = {4'd0,  7'b1000101, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] DEC = {4'd1,  7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] ILL = {4'd1,  7'b0000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [23:0] ER  = {4'd2,  7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [23:0] WR  = {4'd3,  7'b0000000, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] EI  = {4'd4,  7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 1'b0};
  localparam logic [23:0] WI  = {4'd5,  7'b0000000, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] AD  = {4'd6,  7'b0000000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] MR  = {4'd7,  7'b0001100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] WM  = {4'd8,  7'b0000000, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] MW  = {4'd9,  7'b0001010, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] JR  = {4'd10, 7'b0001100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [23:0] JP  = {4'd11, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 1'b0};
  localparam logic [23:0] JU  = {4'd12, 7'b1000000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [23:0] BR  = {4'd13, 7'b0100000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [23:0] BT  = {4'd13, 7'b0110000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [23:0] LK  = {4'd14, 7'b0000000, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};

  typedef struct {
    bit r;
    bit l3;
    logic [5:0] op;
    bit z;
    bit n;
    logic [23:0] e;
  } vec_t;
  vec_t vec[$];
  logic [23:0] sb[$];
  int total = 0, bad = 0;
  bit cl3, cz, cn;
  logic [5:0] cop;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic hdr(input bit l3, input logic [5:0] op, input bit z, input bit n);
    cl3 = l3; cop = op; cz = z; cn = n;
    vec.push_back('{1'b1, l3, op, z, n, Z});
  endtask
  task automatic t(input logic [23:0] e);
    vec.push_back('{1'b0, cl3, cop, cz, cn, e});
  endtask
  task automatic rr();
    vec.push_back('{1'b1, cl3, cop, cz, cn, Z});
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] act, exp;
    int idx;
    hdr(0, 6'b000000, 0, 0); t(F_L); t(DEC); t(ER); t(WR); t(F_L);
    hdr(1, 6'b100011, 0, 0); t(F_W); t(F_W); t(F_L); t(DEC); t(AD); t(MR); t(MR); t(MR); t(WM); t(F_W);
    hdr(0, 6'b001100, 0, 0); t(F_L); t(DEC); t(EI); t(WI); t(F_L);
    hdr(0, 6'b101011, 0, 0); t(F_L); t(DEC); t(AD); t(MW); t(F_L);
    hdr(1, 6'b010000, 0, 0); t(F_W); t(F_W); t(F_L); t(DEC); t(AD); t(JR); t(JR); t(JR); t(JP); t(F_W);
    hdr(0, 6'b000010, 0, 0); t(F_L); t(DEC); t(JU); t(F_L);
    hdr(0, 6'b000100, 1, 1); t(F_L); t(DEC); t(BT); t(F_L);
    hdr(0, 6'b000100, 0, 1); t(F_L); t(DEC); t(BR); t(F_L);
    hdr(0, 6'b100111, 1, 1); t(F_L); t(DEC); t(BR); t(F_L);
    hdr(0, 6'b100111, 0, 0); t(F_L); t(DEC); t(BT); t(F_L);
    hdr(0, 6'b011010, 0, 1); t(F_L); t(DEC); t(BT); t(LK); t(F_L);
    hdr(0, 6'b011010, 1, 0); t(F_L); t(DEC); t(BR); t(F_L); t(DEC);
    hdr(0, 6'b111111, 0, 0); t(F_L); t(ILL); t(F_L); t(ILL);
    hdr(1, 6'b101011, 0, 0); t(F_W); t(F_W); t(F_L); t(DEC); t(AD); t(MW); rr(); t(F_W); t(F_W); t(F_L);
    hdr(1, 6'b101011, 0, 0); rr(); rr(); t(F_W);

    foreach (vec[i]) begin
      @(posedge clk); #1;
      reset = vec[i].r; opcode = vec[i].op; zero = vec[i].z; neg = vec[i].n;
      sb.push_back(vec[i].e);
      @(negedge clk);
      act = vec[i].l3 ? o3 : o1;
      exp = sb.pop_front();
      check($sformatf("row%0d_lat%0d", i, vec[i].l3 ? 3 : 1), 32'(act), 32'(exp));
      check($sformatf("row%0d_rd_wr_excl", i), 32'(act[15] & act[14]), 32'd0);
      check($sformatf("row%0d_rw_pcw_excl", i), 32'(act[8] & act[19]), 32'd0);
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    // lw at MEM_LAT=3: WB_MEM is the 9th cycle after reset release
    opcode = 6'b100011; zero = 1'b0; neg = 1'b0;
    do_reset();
    idx = -1;
    for (int c = 0; c < 20 && idx < 0; c++) begin
      @(negedge clk);
      if (o3[8]) idx = c;
    end
    check("lw3_wb_cycle", 32'(idx), 32'd8);
    check("lw3_wb_state", 32'(o3[23:20]), 32'd8);
`ifdef CTRL_PERF_CNT_EN
    @(negedge clk);
    check("lw3_retired", ret3, 32'd1);
    check("lw3_stall", stl3, 32'd4);
    opcode = 6'b111111;
    do_reset();
    repeat (3) @(negedge clk);
    check("illegal_not_retired", ret1, 32'd0);
    check("illegal_state_fetch", 32'(o1[23:20]), 32'd0);
    opcode = 6'b101011;
    do_reset();
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mw_reset_memwrite", 32'(o3[14]), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mw_reset_retired", ret3, 32'd0);
    check("mw_reset_stall", stl3, 32'd0);
    check("mw_reset_fetch", 32'(o3), 32'(F_W));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that sequences the team's multi-cycle MIPS datapath over one shared instruction/data memory, a single ALU, and the IR/MDR/A/B/ALUOut registers.
- Decodes the opcode in IR and steps fetch/decode/execute/memory/writeback per instruction: R-type, lw, sw, beq, andi, j, jm, bgez, balz.
- Replaces the single-cycle combinational control when the datapath runs multi-cycle; adds configurable memory latency.

Parameters:
- MEM_LAT, 1, cycles each memory access state is held (1..15); memread/memwrite stay asserted for all of them.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag, valid in branch states
- neg  in  1  ALU result sign bit, valid in branch states
- pcwrite  out  1  unconditional PC load
- pcwritecond  out  1  PC load qualified by branch_taken
- branch_taken  out  1  condition result for the current branch state
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memread  out  1
- memwrite  out  1
- irwrite  out  1
- regdst  out  2  00=rt, 01=rd, 10=r31
- memtoreg  out  2  00=ALUOut, 01=MDR, 10=PC
- regwrite  out  1
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=4, 10=sext imm, 11=sext imm<<2
- aluop  out  2  00=add, 01=sub, 10=funct, 11=and
- pcsource  out  2  00=ALU result, 01=ALUOut, 10=jump addr, 11=MDR
- illegal  out  1  one-cycle pulse on unknown opcode
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: state<=FETCH, wait counter<=0. While reset=1, all outputs are forced to 0.
- Outputs decode from state and counter only. Any output not listed for a state is 0.
- FETCH: iord=0, memread=1, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
  - irwrite and pcwrite assert only on the last of MEM_LAT cycles.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011, 101011, 010000 -> ADDR
  - 000100 -> BEQ
  - 001100 -> EXEC_I
  - 000010 -> JUMP
  - 100111 -> BGEZ
  - 011010 -> BALZ
  - any other opcode -> FETCH with illegal=1 for this cycle; no architectural write.
- EXEC_R: alusrca=1, alusrcb=00, aluop=10 -> WB_R.
- WB_R: regdst=01, memtoreg=00, regwrite=1 -> FETCH.
- EXEC_I: alusrca=1, alusrcb=10, aluop=11 -> WB_I.
- WB_I: regdst=00, memtoreg=00, regwrite=1 -> FETCH.
- ADDR: alusrca=1, alusrcb=10, aluop=00. Next: lw -> MEM_RD, sw -> MEM_WR, jm -> JM_RD.
- MEM_RD: iord=1, memread=1 for MEM_LAT cycles -> WB_MEM.
- WB_MEM: regdst=00, memtoreg=01, regwrite=1 -> FETCH.
- MEM_WR: iord=1, memwrite=1 for MEM_LAT cycles -> FETCH.
- JM_RD: iord=1, memread=1 for MEM_LAT cycles -> JM_PC.
- JM_PC: pcsource=11, pcwrite=1 -> FETCH.
- JUMP: pcsource=10, pcwrite=1 -> FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=01, pcsource=01, pcwritecond=1; branch_taken=zero -> FETCH.
- BGEZ: same ALU setup as BEQ; branch_taken=~neg -> FETCH.
- BALZ: same ALU setup as BEQ; branch_taken=neg.
  - Taken -> LINK; not taken -> FETCH.
- LINK: regdst=10, memtoreg=10, regwrite=1 -> FETCH.
  - Writes PC, which already holds the branch target, per ISA definition.
- Wait counter: 4 bits, zeroed on entry to every memory state, increments each cycle.
  - State exits when counter==MEM_LAT-1.
  - MEM_LAT=1 means a single cycle, with no extra stall.
- Reset mid-instruction (including mid-wait): abandons the instruction. No write strobe asserts in the reset cycle or after it; the next cycle is FETCH with counter=0.
- memread and memwrite are never both 1. regwrite and pcwrite never assert in the same cycle.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs retired[31:0] and stall_cycles[31:0], both cleared by reset.
  - retired increments on every transition into FETCH except after illegal.
  - stall_cycles increments on each non-final cycle of any memory state.
  - Both wrap modulo 2^32.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- MEM_LAT=1, R-type (opcode 000000) -> states FETCH, DECODE, EXEC_R, WB_R, FETCH; regwrite=1 only in WB_R with regdst=01.
- MEM_LAT=3, lw (100011) -> FETCH 3 cycles (irwrite only in cycle 3), MEM_RD 3 cycles with memread=1, iord=1; total 9 cycles.
- BALZ with neg=1 -> LINK with regdst=10, memtoreg=10, regwrite=1; with neg=0 -> FETCH directly, regwrite never 1.
- BEQ with zero=1 then zero=0 -> pcwritecond=1 and branch_taken=1 then 0; BGEZ with neg=1 -> branch_taken=0.
- Opcode 111111 -> illegal=1 for one cycle in DECODE, then FETCH; no regwrite/memwrite/pcwrite pulse.
- Assert reset during the 2nd MEM_WR cycle (MEM_LAT=3) -> memwrite=0 in that cycle; after release, FETCH with counter=0; with CTRL_PERF_CNT_EN, retired=0.
